// File: rtl/event_timestamp_packer_if.sv
// Event-in / packet-out bundle of the timestamp packer.
// The master side drives events and readout ready; the slave side is the packer.
interface event_timestamp_packer_if #(
  parameter int SIZE     = 32,
  parameter int ROW_ADDR = 4,
  parameter int COL_ADDR = 4,
  parameter int DEPTH    = 8
);
  localparam int PKT_W = SIZE + ROW_ADDR + COL_ADDR + 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [SIZE-1:0]     timestamp_i;
  logic                event_valid_i;
  logic [COL_ADDR-1:0] x_add_i;
  logic [ROW_ADDR-1:0] y_add_i;
  logic                polarity_i;
  logic                event_ready_o;
  logic [PKT_W-1:0]    pkt_o;
  logic                pkt_valid_o;
  logic                pkt_ready_i;
  logic [CNT_W-1:0]    fifo_count_o;
  logic [7:0]          drop_count_o;

  modport master (
    output timestamp_i, event_valid_i, x_add_i, y_add_i, polarity_i, pkt_ready_i,
    input  event_ready_o, pkt_o, pkt_valid_o, fifo_count_o, drop_count_o
  );

  modport slave (
    input  timestamp_i, event_valid_i, x_add_i, y_add_i, polarity_i, pkt_ready_i,
    output event_ready_o, pkt_o, pkt_valid_o, fifo_count_o, drop_count_o
  );
endinterface

// File: rtl/event_timestamp_packer.sv
// Packs granted pixel events with the wall-clock timestamp and a wrap marker,
// buffering the words in a first-word-fall-through FIFO for readout.
module event_timestamp_packer #(
  parameter int SIZE     = 32,
  parameter int ROW_ADDR = 4,
  parameter int COL_ADDR = 4,
  parameter int DEPTH    = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  event_timestamp_packer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PKT_W = SIZE + ROW_ADDR + COL_ADDR + 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       drop_q, drop_d;
  logic [SIZE-1:0]  prev_ts_q;
  logic             wrap_pending_q, wrap_pending_d;
  logic             wrap_det, accept, drop, pop, full, empty;
  logic [PKT_W-1:0] wr_word;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign wrap_det = (bus.timestamp_i < prev_ts_q);
  assign accept   = bus.event_valid_i && !full;
  assign drop     = bus.event_valid_i && full;
  assign pop      = !empty && bus.pkt_ready_i;
  // A wrap seen in the accepting cycle is folded straight into that word.
  assign wr_word  = {wrap_pending_q | wrap_det, bus.polarity_i, bus.y_add_i,
                     bus.x_add_i, bus.timestamp_i};

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    drop_d         = drop_q;
    wrap_pending_d = wrap_pending_q | wrap_det;
    if (accept) begin
      wr_ptr_d       = wr_ptr_q + PTR_W'(1);
      wrap_pending_d = 1'b0;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      drop_q         <= '0;
      prev_ts_q      <= '0;
      wrap_pending_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      drop_q         <= drop_d;
      prev_ts_q      <= bus.timestamp_i;
      wrap_pending_q <= wrap_pending_d;
    end
  end

  // Storage carries no reset; validity is defined entirely by count_q.
  always_ff @(posedge clk_i) begin
    if (accept && !reset_i) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  assign bus.event_ready_o = !full;
  assign bus.pkt_valid_o   = !empty;
  assign bus.pkt_o         = mem_q[rd_ptr_q];
  assign bus.fifo_count_o  = count_q;
  assign bus.drop_count_o  = drop_q;
endmodule

// File: tb/tb_event_timestamp_packer.sv
// Randomized and directed bench for event_timestamp_packer with a queue-based
// reference model and a decoupled output monitor.
module tb_event_timestamp_packer;
  localparam int SIZE  = 32;
  localparam int ROW   = 4;
  localparam int COL   = 4;
  localparam int DEPTH = 8;
  localparam int PKT_W = SIZE + ROW + COL + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  event_timestamp_packer_if #(.SIZE(SIZE), .ROW_ADDR(ROW), .COL_ADDR(COL), .DEPTH(DEPTH)) bus();

  event_timestamp_packer #(.SIZE(SIZE), .ROW_ADDR(ROW), .COL_ADDR(COL), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  logic [PKT_W-1:0] exp_q[$];
  int          mdl_count = 0;
  int          mdl_drops = 0;
  logic [31:0] mdl_prev  = '0;
  bit          mdl_pend  = 1'b0;
  bit          started   = 1'b0;
  bit          m_wrap, m_acc, m_pop;
  logic [31:0] cur_ts;
  int          d0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO occupancy, wrap marker and drop counter from the rules.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdl_count = 0;
      mdl_drops = 0;
      mdl_prev  = '0;
      mdl_pend  = 1'b0;
      started   = 1'b1;
    end else if (started) begin
      m_wrap = (bus.timestamp_i < mdl_prev);
      m_acc  = bus.event_valid_i && (mdl_count < DEPTH);
      m_pop  = bus.pkt_ready_i && (mdl_count > 0);
      if (m_acc) begin
        exp_q.push_back({mdl_pend | m_wrap, bus.polarity_i, bus.y_add_i,
                         bus.x_add_i, bus.timestamp_i});
        mdl_pend = 1'b0;
      end else begin
        mdl_pend = mdl_pend | m_wrap;
        if (bus.event_valid_i && mdl_drops < 255) mdl_drops++;
      end
      mdl_count = mdl_count + int'(m_acc) - int'(m_pop);
      mdl_prev  = bus.timestamp_i;
    end
  end

  // Monitor: status every cycle, word compare on each handshake.
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("fifo_count", 64'(bus.fifo_count_o), 64'(exp_q.size()));
      chk("pkt_valid", 64'(bus.pkt_valid_o), 64'(exp_q.size() != 0));
      chk("event_ready", 64'(bus.event_ready_o), 64'(exp_q.size() != DEPTH));
      chk("drop_count", 64'(bus.drop_count_o), 64'(mdl_drops));
      if (bus.pkt_valid_o && bus.pkt_ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_bad++;
          $display("FAIL pop_empty: got word %0h expected no word", bus.pkt_o);
        end else begin
          chk("pkt_word", 64'(bus.pkt_o), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [3:0] x, input logic [3:0] y,
                       input bit pol, input bit rdy);
    bus.event_valid_i = v;
    bus.x_add_i       = x;
    bus.y_add_i       = y;
    bus.polarity_i    = pol;
    bus.timestamp_i   = cur_ts;
    bus.pkt_ready_i   = rdy;
    @(posedge clk);
    #1;
    cur_ts = cur_ts + 32'd1;
  endtask

  task automatic step(input bit v, input bit rdy);
    drive(v, 4'($urandom), 4'($urandom), 1'($urandom), rdy);
  endtask

  initial begin
    cur_ts = '0;
    bus.event_valid_i = 1'b0;
    bus.x_add_i       = '0;
    bus.y_add_i       = '0;
    bus.polarity_i    = 1'b0;
    bus.timestamp_i   = '0;
    bus.pkt_ready_i   = 1'b0;
    rst = 1'b1;
    step(0, 0);
    step(0, 0);
    rst = 1'b0;
    chk("rst_count", 64'(bus.fifo_count_o), 64'd0);
    chk("rst_valid", 64'(bus.pkt_valid_o), 64'd0);
    chk("rst_ready", 64'(bus.event_ready_o), 64'd1);
    chk("rst_drops", 64'(bus.drop_count_o), 64'd0);

    // single event
    cur_ts = 32'd100;
    drive(1, 4'd3, 4'd5, 1'b1, 0);
    chk("t1_pkt", 64'(bus.pkt_o), 64'({1'b0, 1'b1, 4'd5, 4'd3, 32'd100}));
    chk("t1_count", 64'(bus.fifo_count_o), 64'd1);
    step(0, 1);
    chk("t1_valid_after_pop", 64'(bus.pkt_valid_o), 64'd0);

    // overfill by two, then drain in order
    repeat (10) step(1, 0);
    chk("t2_ready", 64'(bus.event_ready_o), 64'd0);
    chk("t2_drops", 64'(bus.drop_count_o), 64'd2);
    chk("t2_count", 64'(bus.fifo_count_o), 64'd8);
    repeat (8) step(0, 1);
    chk("t2_drained", 64'(bus.fifo_count_o), 64'd0);

    // full with simultaneous event and pop, then push+pop at 7
    repeat (8) step(1, 0);
    d0 = int'(bus.drop_count_o);
    step(1, 1);
    chk("t3_count_full_pop", 64'(bus.fifo_count_o), 64'd7);
    chk("t3_drop_inc", 64'(bus.drop_count_o), 64'(d0 + 1));
    step(1, 1);
    chk("t3_count_push_pop", 64'(bus.fifo_count_o), 64'd7);
    repeat (7) step(0, 1);

    // timestamp wrap with no events, then two events
    cur_ts = 32'hFFFF_FFFE;
    repeat (3) step(0, 0);
    cur_ts = 32'd2;
    step(1, 0);
    step(1, 0);
    chk("t4_wrap_set", 64'(bus.pkt_o[PKT_W-1]), 64'd1);
    chk("t4_ts_first", 64'(bus.pkt_o[SIZE-1:0]), 64'd2);
    step(0, 1);
    chk("t4_wrap_clear", 64'(bus.pkt_o[PKT_W-1]), 64'd0);
    step(0, 1);

    // wrap on a dropped event carries to the next accepted one
    repeat (8) step(1, 0);
    cur_ts = 32'd0;
    step(1, 0);
    step(0, 1);
    step(1, 0);
    repeat (7) step(0, 1);
    chk("t5_tail_wrap", 64'(bus.pkt_o[PKT_W-1]), 64'd1);
    step(0, 1);

    // drop saturation and mid-stream reset
    repeat (8) step(1, 0);
    repeat (300) step(1, 0);
    chk("t6_drop_sat", 64'(bus.drop_count_o), 64'd255);
    repeat (4) step(0, 1);
    chk("t6_count4", 64'(bus.fifo_count_o), 64'd4);
    rst = 1'b1;
    step(1, 0);
    rst = 1'b0;
    chk("t6_rst_count", 64'(bus.fifo_count_o), 64'd0);
    chk("t6_rst_valid", 64'(bus.pkt_valid_o), 64'd0);
    chk("t6_rst_drops", 64'(bus.drop_count_o), 64'd0);
    chk("t6_rst_ready", 64'(bus.event_ready_o), 64'd1);

    // randomized traffic with occasional timestamp jumps
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) cur_ts = $urandom;
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55);
    end
    repeat (DEPTH + 2) step(0, 1);
    chk("final_empty", 64'(bus.fifo_count_o), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/event_timestamp_packer.md
# event_timestamp_packer

Downstream consumer of the wall-clock timestamp counter in the pixel-level arbiter hierarchy. On each granted pixel event it captures the current free-running timestamp and packs it with the pixel address and polarity into one event word. Each word also carries a timestamp-wrap marker. Words are buffered in a first-word-fall-through FIFO and presented on a valid/ready stream to the readout interface.

## Interface

Parameters:
- SIZE, 32, timestamp width; equals wall-clock counter width
- ROW_ADDR, 4, row (y) address width
- COL_ADDR, 4, column (x) address width
- DEPTH, 8, FIFO depth in words; power of two, ≥ 2
- PKT_W, SIZE+ROW_ADDR+COL_ADDR+2, packet width (derived, not overridden)

Ports:
- clk_i  in  1  single clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- timestamp_i  in  SIZE  free-running count from wall clock
- event_valid_i  in  1  arbiter has a granted event this cycle
- x_add_i  in  COL_ADDR  column address of granted pixel
- y_add_i  in  ROW_ADDR  row address of granted pixel
- polarity_i  in  1  event polarity (1 = ON, 0 = OFF)
- event_ready_o  out  1  FIFO can accept an event this cycle
- pkt_o  out  PKT_W  head word {wrap, polarity, y, x, timestamp}, MSB first
- pkt_valid_o  out  1  pkt_o holds a valid word
- pkt_ready_i  in  1  readout consumes head word
- fifo_count_o  out  $clog2(DEPTH)+1  words stored
- drop_count_o  out  8  events lost to full FIFO, saturating

## Operation

- Accept: event_valid_i && event_ready_o. The word written is {wrap_flag, polarity_i, y_add_i, x_add_i, timestamp_i}, sampled that same cycle.
- event_ready_o = (fifo_count_o != DEPTH). This is combinational from count only and does not depend on pkt_ready_i.
- Drop: event_valid_i && !event_ready_o. No write occurs, and drop_count_o increments. drop_count_o holds at 255 once reached.
- Pop: pkt_valid_o && pkt_ready_i. The read pointer advances.
- pkt_valid_o = (fifo_count_o != 0). pkt_o is the word at the read pointer and is undefined/don't-care when empty.
- Simultaneous accept and pop: both occur and the count is unchanged. This is legal at any non-full, non-empty count. When full, the pop happens and the event is still dropped. When empty, only the push happens.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Wrap tracking:
  - prev_ts register samples timestamp_i every cycle.
  - A wrap is detected when timestamp_i < prev_ts.
  - wrap_pending is set on detection and cleared on the next accepted event.
- Wrap bit of a written word = wrap_pending OR wrap detected in the same cycle. Accepting the event clears wrap_pending even if a wrap is detected that cycle.
- A dropped event does not clear wrap_pending; the marker carries to the next accepted event.
- FIFO is in-order; no reordering.

## Timing

- Reset, synchronous, takes effect at the first rising edge with reset_i high:
  - pointers, fifo_count_o, drop_count_o, prev_ts, wrap_pending all go to 0
  - pkt_valid_o = 0, event_ready_o = 1
- Reset mid-operation discards all stored words and the pending wrap marker. An event presented during a reset cycle is ignored and not counted as dropped.
- Latency: an event accepted at edge N gives pkt_valid_o = 1 and the word on pkt_o after edge N (visible in cycle N+1).
- Throughput: one accept and one pop per cycle, sustained.
- Counter and flag updates are registered and visible the cycle after the causing edge.
- fifo_count_o never exceeds DEPTH and never underflows.

## Test plan

- Reset, then a single event with x=3, y=5, polarity=1, timestamp_i=100. Expect next cycle: pkt_valid_o=1, pkt_o={0,1,5,3,100}, fifo_count_o=1. Pop, and pkt_valid_o=0 the following cycle.
- Hold pkt_ready_i=0 and push 10 events with DEPTH=8. Expect:
  - event_ready_o=0 after the 8th
  - drop_count_o=2, fifo_count_o=8
  - then drain 8 words in push order with the correct timestamps.
- Fill to 8, then in one cycle assert event_valid_i and pkt_ready_i. Expect the pop to occur, the event dropped, count=7, drop_count_o+1. Next cycle, push+pop together: count stays 7.
- Drive timestamp_i 0xFFFFFFFE, 0xFFFFFFFF, 0x0 with no events, then an event at 0x2. Expect wrap bit=1 on that word and wrap bit=0 on the following event.
- Wrap in the same cycle as an event while the FIFO is full, i.e. dropped. Expect the next accepted event to carry wrap=1.
- Force 300 drops. Expect drop_count_o saturates at 255. Assert reset_i mid-stream with 4 words stored. Expect next cycle count=0, pkt_valid_o=0, drop_count_o=0, event_ready_o=1.
